fifo_ptr_ctrl: RTL and testbench

//   Pointer/control side of the two-pointer circular FIFO. Owns the (ADDR_WIDTH+1)-bit write and read

---
 rtl/fifo_ptr_ctrl.sv | 124 ++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ptr_ctrl
// Pointer/control half of a two-pointer circular FIFO. It owns the write and
// read pointers. Each pointer carries one extra wrap bit, which lets the
// external status block tell full from empty. That block feeds
// fifo_full/fifo_empty back here so that client requests can be gated.
//
// Ports
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   wr_en, rd_en    client write / read requests
//   clr_err         clears the sticky error flags
//   fifo_full/empty status flags computed externally from wptr/rptr
//   wptr, rptr      registered pointers (MSB is the wrap bit)
//   mem_we, waddr   write strobe and address for the storage array
//   mem_re, raddr   read strobe and address for the storage array
//   fifo_count      registered occupancy, 0..DEPTH
//   fifo_afull      registered, count >= AF_LEVEL
//   fifo_aempty     registered, count <= AE_LEVEL
//   wr_overflow     one-cycle pulse after a write is rejected because full
//   rd_underflow    one-cycle pulse after a read is rejected because empty
//   err_sticky      {overflow_seen, underflow_seen}, held until clr_err/rst
// ---------------------------------------------------------------------------
module fifo_ptr_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  clr_err,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_afull,
    output logic                  fifo_aempty,
    output logic                  wr_overflow,
    output logic                  rd_underflow,
    output logic [1:0]            err_sticky
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_LEVEL);

    logic          wacc;
    logic          racc;
    logic          wr_rejected;
    logic          rd_rejected;
    logic [PW-1:0] count_next;

    // A request is accepted only when the current registered-pointer flags
    // allow it. Rejected requests leave the pointers untouched.
    assign wacc        = wr_en & ~fifo_full;
    assign racc        = rd_en & ~fifo_empty;
    assign wr_rejected = wr_en & fifo_full;
    assign rd_rejected = rd_en & fifo_empty;

    assign mem_we = wacc;
    assign mem_re = racc;
    assign waddr  = wptr[ADDR_WIDTH-1:0];
    assign raddr  = rptr[ADDR_WIDTH-1:0];

    // The next occupancy value. A simultaneous accepted read and write
    // cancel each other out. The almost flags are derived from this value so
    // that they change in the same cycle as fifo_count.
    always_comb begin
        count_next = fifo_count;
        if (wacc && !racc) begin
            count_next = fifo_count + PW'(1);
        end else if (racc && !wacc) begin
            count_next = fifo_count - PW'(1);
        end
    end

    // The pointers wrap naturally modulo 2**PW. The address bits therefore
    // roll over from DEPTH-1 to 0 while the MSB toggles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wacc) wptr <= wptr + PW'(1);
            if (racc) rptr <= rptr + PW'(1);
        end
    end

    // Occupancy and the almost-full / almost-empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_count  <= '0;
            fifo_afull  <= 1'b0;
            fifo_aempty <= 1'b1;
        end else begin
            fifo_count  <= count_next;
            fifo_afull  <= (count_next >= AF_LVL);
            fifo_aempty <= (count_next <= AE_LVL);
        end
    end

    // Error pulses fire once for each offending cycle. Each sticky bit is set
    // by its pulse. If the set and clr_err happen in the same cycle, the set
    // wins, so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
            err_sticky   <= 2'b00;
        end else begin
            wr_overflow   <= wr_rejected;
            rd_underflow  <= rd_rejected;
            err_sticky[1] <= wr_rejected | (err_sticky[1] & ~clr_err);
            err_sticky[0] <= rd_rejected | (err_sticky[0] & ~clr_err);
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ptr_ctrl
// Self-checking bench for fifo_ptr_ctrl. It models the status block
// (full/empty from the pointers) and keeps its own reference model. That
// model counts the total writes and reads accepted since reset and derives
// the pointers, occupancy and flags from those totals.
// ---------------------------------------------------------------------------
module tb_fifo_ptr_ctrl;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic          clr_err;
    logic          fifo_full;
    logic          fifo_empty;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          mem_we;
    logic [AW-1:0] waddr;
    logic          mem_re;
    logic [AW-1:0] raddr;
    logic [PW-1:0] fifo_count;
    logic          fifo_afull;
    logic          fifo_aempty;
    logic          wr_overflow;
    logic          rd_underflow;
    logic [1:0]    err_sticky;

    int check_cnt = 0;
    int fail_cnt  = 0;

    // Reference model state: totals accepted since the last reset.
    int wr_total = 0;
    int rd_total = 0;
    bit m_ovf    = 1'b0;
    bit m_udf    = 1'b0;
    bit m_ovf_s  = 1'b0;
    bit m_udf_s  = 1'b0;

    fifo_ptr_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .wptr         (wptr),
        .rptr         (rptr),
        .mem_we       (mem_we),
        .waddr        (waddr),
        .mem_re       (mem_re),
        .raddr        (raddr),
        .fifo_count   (fifo_count),
        .fifo_afull   (fifo_afull),
        .fifo_aempty  (fifo_aempty),
        .wr_overflow  (wr_overflow),
        .rd_underflow (rd_underflow),
        .err_sticky   (err_sticky)
    );

    // Stand-in for the status block. Full means the address bits are equal
    // and the wrap bits differ; empty means the pointers are identical.
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign fifo_empty = (wptr == rptr);

    always #5 clk = ~clk;

    function automatic int occ();
        return wr_total - rd_total;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
            $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        wr_total = 0;
        rd_total = 0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_ovf_s  = 1'b0;
        m_udf_s  = 1'b0;
    endtask

    // Compare every registered output against the model.
    task automatic checkRegs();
        checkOutput("wptr",         32'(wptr),         32'(wr_total % 16));
        checkOutput("rptr",         32'(rptr),         32'(rd_total % 16));
        checkOutput("fifo_count",   32'(fifo_count),   32'(occ()));
        checkOutput("fifo_afull",   32'(fifo_afull),   32'(occ() >= AF));
        checkOutput("fifo_aempty",  32'(fifo_aempty),  32'(occ() <= AE));
        checkOutput("fifo_full",    32'(fifo_full),    32'(occ() == DEPTH));
        checkOutput("fifo_empty",   32'(fifo_empty),   32'(occ() == 0));
        checkOutput("wr_overflow",  32'(wr_overflow),  32'(m_ovf));
        checkOutput("rd_underflow", 32'(rd_underflow), 32'(m_udf));
        checkOutput("err_sticky",   32'(err_sticky),   32'({m_ovf_s, m_udf_s}));
    endtask

    // Drive one cycle of requests. Check the combinational strobes before
    // the edge, advance the model at the edge, then check the registers.
    task automatic applyStimulus(input bit wr, input bit rd, input bit clr);
        bit full_now;
        bit empty_now;
        wr_en   = wr;
        rd_en   = rd;
        clr_err = clr;
        #1;
        full_now  = (occ() == DEPTH);
        empty_now = (occ() == 0);
        checkOutput("mem_we", 32'(mem_we), 32'(wr && !full_now));
        checkOutput("mem_re", 32'(mem_re), 32'(rd && !empty_now));
        checkOutput("waddr",  32'(waddr),  32'(wr_total % DEPTH));
        checkOutput("raddr",  32'(raddr),  32'(rd_total % DEPTH));
        @(posedge clk);
        m_ovf   = wr && full_now;
        m_udf   = rd && empty_now;
        m_ovf_s = m_ovf || (m_ovf_s && !clr);
        m_udf_s = m_udf || (m_udf_s && !clr);
        if (wr && !full_now)  wr_total++;
        if (rd && !empty_now) rd_total++;
        #1;
        checkRegs();
    endtask

    task automatic doReset(input bit wr);
        rst     = 1'b1;
        wr_en   = wr;
        rd_en   = 1'b0;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkRegs();
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkRegs();

        // Fill to full, then push once more to provoke an overflow.
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);

        // While full, read and write together, then clear the sticky errors.
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Drain to empty with one extra read for an underflow.
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b0);

        // Set and clear together: the set must win.
        applyStimulus(1'b0, 1'b1, 1'b1);

        // Steady state: preload 3, then stream so the addresses wrap.
        doReset(1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b1, 1'b1, 1'b0);

        // Reset in mid-stream with a write pending.
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        doReset(1'b1);

        // Random phases that lean toward filling or draining.
        for (int i = 0; i < 600; i++) begin
            int wbias;
            wbias = ((i / 40) % 2 == 0) ? 75 : 25;
            if ($urandom_range(99) == 0) begin
                doReset($urandom_range(1) == 1);
            end else begin
                applyStimulus($urandom_range(99) < wbias,
                              $urandom_range(99) >= wbias,
                              $urandom_range(9) == 0);
            end
        end

        $display("[TB] %0d/%0d checks passed", check_cnt - fail_cnt, check_cnt);
        $finish;
    end

endmodule
